// File: rtl/sticky_shift_seq.sv
// Multi-cycle right shifter for wide FP mantissas. It shifts by up to 32 bits per cycle
// and ORs every bit it shifts out into a sticky flag.
module sticky_shift_seq #(
  parameter int WID  = 128,
  parameter int AMTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ld,
  input  logic [AMTW-1:0] i_amt,
  input  logic [WID-1:0]  i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [WID-1:0]  o_o,
  output logic            o_sticky
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [AMTW-1:0] C_WID = AMTW'(WID);
  localparam logic [AMTW-1:0] C_32  = AMTW'(32);

  // Prefix-OR slice: returns |v[a:0].
  function automatic logic prefix_or(input logic [4:0] a, input logic [31:0] v);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (5'(i) <= a) acc = acc | v[i];
      else            acc = acc;
    end
    return acc;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [WID-1:0]  r_q, r_o, w_q_sh;
  logic [AMTW-1:0] r_r, w_r0, w_s, w_r_sub;
  logic [4:0]      w_a;
  logic            r_sticky, w_or, w_accept;

  assign w_accept = i_ld && (r_state != S_SHIFT);
  assign w_r0     = (i_amt > C_WID) ? C_WID : i_amt;
  assign w_s      = (r_r > C_32) ? C_32 : r_r;
  // A 5-bit r of 0 can only mean r==32 here, and 0-1 wraps to the needed 31.
  assign w_a      = (r_r > C_32) ? 5'd31 : (r_r[4:0] - 5'd1);
  assign w_q_sh   = r_q >> w_s;
  assign w_r_sub  = r_r - w_s;
  assign w_or     = prefix_or(w_a, r_q[31:0]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; DONE lasts exactly one cycle unless a new op is accepted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_ld) w_state_nxt = (w_r0 != '0) ? S_SHIFT : S_DONE;
        else      w_state_nxt = S_IDLE;
      end
      S_SHIFT: begin
        if (w_r_sub == '0) w_state_nxt = S_DONE;
        else               w_state_nxt = S_SHIFT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand, remaining amount, sticky and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q      <= '0;
      r_r      <= '0;
      r_o      <= '0;
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_q      <= i_b;
      r_r      <= w_r0;
      r_sticky <= 1'b0;
      if (w_r0 == '0) r_o <= i_b;
      else            r_o <= r_o;
    end else if (r_state == S_SHIFT) begin
      r_q      <= w_q_sh;
      r_r      <= w_r_sub;
      r_sticky <= r_sticky | w_or;
      if (w_r_sub == '0) r_o <= w_q_sh;
      else               r_o <= r_o;
    end else begin
      r_q      <= r_q;
      r_r      <= r_r;
      r_o      <= r_o;
      r_sticky <= r_sticky;
    end
  end

  assign o_busy   = (r_state == S_SHIFT);
  assign o_done   = (r_state == S_DONE);
  assign o_o      = r_o;
  assign o_sticky = r_sticky;

endmodule
